// File: rtl/mem_rd_ctrl.sv
// mem_rd_ctrl: streams num_row consecutive SRAM rows into a systolic array.
// It tracks each row through the array and signals completion when the
// last partial-sum row has left the array.
//
// Read data timing: mem_rd_en/mem_rd_addr are registered. The row for a
// read is sampled from mem_rd_data on the RD_LATENCY-th rising edge after
// the read strobe is launched. It is then presented on array_in_data with
// array_in_valid RD_LATENCY cycles after the strobe cycle.
module mem_rd_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int ARRAY_DIM  = 8,
  parameter int RD_LATENCY = 1,
  parameter int PIPE_LAT   = 2*ARRAY_DIM-1
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            start,
  input  logic [DATA_WIDTH-1:0]           num_row,
  input  logic [ADDR_WIDTH-1:0]           base_addr,
  output logic                            mem_rd_en,
  output logic [ADDR_WIDTH-1:0]           mem_rd_addr,
  input  logic [ARRAY_DIM*DATA_WIDTH-1:0] mem_rd_data,
  output logic                            array_in_valid,
  output logic [ARRAY_DIM*DATA_WIDTH-1:0] array_in_data,
  output logic                            sys_done,
  output logic                            busy,
  output logic                            rd_done
);

  localparam int ROW_W = ARRAY_DIM*DATA_WIDTH;

  // Selects the final stage of the array-latency line. That stage drives
  // sys_done directly, so it is excluded from the "still in flight" test.
  localparam logic [PIPE_LAT-1:0] SYS_LAST_MASK = PIPE_LAT'(1) << (PIPE_LAT-1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   rowCnt_q;
  logic [ADDR_WIDTH-1:0]   rdAddr_q;
  logic [RD_LATENCY-1:0]   rdLine_q;
  logic                    busy_q;
  logic                    rdDone_q;
  logic                    aivValid_q;
  logic [ROW_W-1:0]        aivData_q;
  logic [PIPE_LAT-1:0]     sysLine_q;
  logic                    pipeIdle;

  // Nothing upstream of the final sys_done stage is still carrying a row.
  // In DRAIN, this means the last sys_done is high now, or already past.
  assign pipeIdle = (rdLine_q == '0) && !aivValid_q &&
                    ((sysLine_q & ~SYS_LAST_MASK) == '0);

  // Control FSM. It launches reads, shifts the read-latency line (bit 0 is
  // the read strobe) and reports job completion.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      rowCnt_q <= '0;
      rdAddr_q <= '0;
      rdLine_q <= '0;
      busy_q   <= 1'b0;
      rdDone_q <= 1'b0;
    end else begin
      rdDone_q <= 1'b0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rdLine_q[i] <= rdLine_q[i-1];
      end
      case (state_q)
        IDLE: begin
          if (start && !rdDone_q) begin
            if (num_row != '0) begin
              rowCnt_q    <= num_row;
              rdAddr_q    <= base_addr;
              rdLine_q[0] <= 1'b1;
              busy_q      <= 1'b1;
              state_q     <= READ;
            end else begin
              rdDone_q <= 1'b1;
            end
          end
        end
        READ: begin
          if (rowCnt_q == DATA_WIDTH'(1)) begin
            rdLine_q[0] <= 1'b0;
            state_q     <= DRAIN;
          end else begin
            rowCnt_q <= rowCnt_q - DATA_WIDTH'(1);
            rdAddr_q <= rdAddr_q + ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          if (pipeIdle) begin
            rdDone_q <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Array-side datapath: registers the returned row, then delays its valid
  // flag by the array latency to produce sys_done.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aivValid_q <= 1'b0;
      aivData_q  <= '0;
      sysLine_q  <= '0;
    end else begin
      aivValid_q <= rdLine_q[RD_LATENCY-1];
      if (rdLine_q[RD_LATENCY-1]) begin
        aivData_q <= mem_rd_data;
      end
      sysLine_q[0] <= aivValid_q;
      for (int i = 1; i < PIPE_LAT; i++) begin
        sysLine_q[i] <= sysLine_q[i-1];
      end
    end
  end

  assign mem_rd_en      = rdLine_q[0];
  assign mem_rd_addr    = rdAddr_q;
  assign array_in_valid = aivValid_q;
  assign array_in_data  = aivData_q;
  assign sys_done       = sysLine_q[PIPE_LAT-1];
  assign busy           = busy_q;
  assign rd_done        = rdDone_q;

endmodule

// File: tb/tb_mem_rd_ctrl.sv
// tb_mem_rd_ctrl: directed jobs for mem_rd_ctrl with default parameters.
// The stimulus pushes expected events into queues; a negedge monitor pops
// and compares them whenever the DUT raises an output.
module tb_mem_rd_ctrl;

  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int AD    = 8;
  localparam int ROW_W = AD*DW;
  localparam int LAT   = 1;
  localparam int PIPE  = 2*AD-1;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             start = 1'b0;
  logic [DW-1:0]    num_row = '0;
  logic [AW-1:0]    base_addr = '0;
  logic             mem_rd_en;
  logic [AW-1:0]    mem_rd_addr;
  logic [ROW_W-1:0] mem_rd_data;
  logic             array_in_valid;
  logic [ROW_W-1:0] array_in_data;
  logic             sys_done;
  logic             busy;
  logic             rd_done;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  int               expRdCyc[$];
  logic [AW-1:0]    expRdAddr[$];
  int               expAivCyc[$];
  logic [ROW_W-1:0] expAivData[$];
  int               expSysCyc[$];
  int               expDoneCyc[$];

  mem_rd_ctrl dut (
    .clk            (clk),
    .rstn           (rstn),
    .start          (start),
    .num_row        (num_row),
    .base_addr      (base_addr),
    .mem_rd_en      (mem_rd_en),
    .mem_rd_addr    (mem_rd_addr),
    .mem_rd_data    (mem_rd_data),
    .array_in_valid (array_in_valid),
    .array_in_data  (array_in_data),
    .sys_done       (sys_done),
    .busy           (busy),
    .rd_done        (rd_done)
  );

  // Clock, cycle counter and a global watchdog
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Each element holds the row address in its upper byte and its element
  // index in the lower byte, so every row is distinct and recognisable.
  function automatic logic [ROW_W-1:0] rowPattern(input logic [AW-1:0] a);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int e = 0; e < AD; e++) r[e*DW +: DW] = {a, 8'(e)};
    return r;
  endfunction

  // SRAM model with single-cycle read latency: the row for the current
  // address is available to the controller's next sampling edge.
  assign mem_rd_data = rowPattern(mem_rd_addr);

  task automatic checkOutput(input string name, input logic [ROW_W-1:0] act,
                             input logic [ROW_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic reportUnexpected(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got 1 with no event expected, expected 0 (cycle %0d)", name, cyc);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_mem_rd_en"},      ROW_W'(mem_rd_en),      '0);
    checkOutput({tag, "_mem_rd_addr"},    ROW_W'(mem_rd_addr),    '0);
    checkOutput({tag, "_array_in_valid"}, ROW_W'(array_in_valid), '0);
    checkOutput({tag, "_array_in_data"},  array_in_data,          '0);
    checkOutput({tag, "_sys_done"},       ROW_W'(sys_done),       '0);
    checkOutput({tag, "_busy"},           ROW_W'(busy),           '0);
    checkOutput({tag, "_rd_done"},        ROW_W'(rd_done),        '0);
  endtask

  function automatic bit queuesEmpty();
    return expRdCyc.size() == 0 && expAivCyc.size() == 0 &&
           expSysCyc.size() == 0 && expDoneCyc.size() == 0;
  endfunction

  task automatic flushQueues();
    expRdCyc.delete();  expRdAddr.delete();
    expAivCyc.delete(); expAivData.delete();
    expSysCyc.delete(); expDoneCyc.delete();
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulses start for the current cycle. When the request should be
  // accepted, it also queues the full expected event timeline.
  task automatic applyStimulus(input int n, input logic [AW-1:0] base, input bit expectAccept);
    int s;
    logic [AW-1:0] a;
    s = cyc;
    start = 1'b1;
    num_row = DW'(n);
    base_addr = base;
    if (expectAccept) begin
      for (int k = 0; k < n; k++) begin
        a = base + AW'(k);
        expRdCyc.push_back(s + 1 + k);
        expRdAddr.push_back(a);
        expAivCyc.push_back(s + 1 + k + LAT);
        expAivData.push_back(rowPattern(a));
        expSysCyc.push_back(s + 1 + k + LAT + PIPE);
      end
      expDoneCyc.push_back((n == 0) ? s + 1 : s + n + LAT + PIPE + 1);
    end
    step(1);
    start = 1'b0;
    num_row = '0;
    base_addr = '0;
  endtask

  task automatic waitDrain(input string name, input int budget);
    for (int i = 0; i < budget && !queuesEmpty(); i++) step(1);
    checks++;
    if (!queuesEmpty()) begin
      errors++;
      $display("[TB] FAIL %s: %0d events still pending after %0d cycles, expected 0",
               name, expRdCyc.size() + expAivCyc.size() + expSysCyc.size() + expDoneCyc.size(),
               budget);
      flushQueues();
    end
    step(3);
  endtask

  // Monitor: every high output cycle must match the head of its queue
  always @(negedge clk) begin
    int c;
    if (rstn) begin
      if (mem_rd_en) begin
        if (expRdCyc.size() == 0) reportUnexpected("mem_rd_en");
        else begin
          c = expRdCyc.pop_front();
          checkOutput("rd_cycle", ROW_W'(cyc), ROW_W'(c));
          checkOutput("rd_addr", ROW_W'(mem_rd_addr), ROW_W'(expRdAddr.pop_front()));
        end
      end
      if (array_in_valid) begin
        if (expAivCyc.size() == 0) reportUnexpected("array_in_valid");
        else begin
          c = expAivCyc.pop_front();
          checkOutput("aiv_cycle", ROW_W'(cyc), ROW_W'(c));
          checkOutput("aiv_data", array_in_data, expAivData.pop_front());
        end
      end
      if (sys_done) begin
        if (expSysCyc.size() == 0) reportUnexpected("sys_done");
        else begin
          c = expSysCyc.pop_front();
          checkOutput("sys_done_cycle", ROW_W'(cyc), ROW_W'(c));
          checkOutput("busy_in_job", ROW_W'(busy), ROW_W'(1));
        end
      end
      if (rd_done) begin
        if (expDoneCyc.size() == 0) reportUnexpected("rd_done");
        else begin
          c = expDoneCyc.pop_front();
          checkOutput("rd_done_cycle", ROW_W'(cyc), ROW_W'(c));
          checkOutput("busy_at_rd_done", ROW_W'(busy), ROW_W'(0));
        end
      end
    end
  end

  // Directed scenario sequence
  initial begin
    int s;
    $display("[TB] start");
    #1;
    checkResetOutputs("por");
    step(2);
    rstn = 1'b1;
    step(2);

    // Basic job: 4 rows from 0x10
    applyStimulus(4, 8'h10, 1'b1);
    waitDrain("job_basic", 40);

    // Address wrap: 0xFE, 0xFF, 0x00
    applyStimulus(3, 8'hFE, 1'b1);
    waitDrain("job_wrap", 40);

    // Zero-row job: immediate rd_done, no reads, busy low
    applyStimulus(0, 8'h55, 1'b1);
    waitDrain("job_zero", 10);

    // A second start while busy is ignored. A start in the rd_done cycle is
    // also ignored. The job started one cycle later repeats the first
    // job's timing.
    s = cyc;
    applyStimulus(4, 8'h10, 1'b1);
    step(1);
    applyStimulus(6, 8'h40, 1'b0);
    while (cyc < s + 4 + LAT + PIPE + 1) step(1);
    applyStimulus(5, 8'h33, 1'b0);
    applyStimulus(4, 8'h10, 1'b1);
    waitDrain("job_back2back", 60);

    // Reset in the middle of an 8-row job, between clock edges
    applyStimulus(8, 8'h20, 1'b1);
    step(1);
    #2;
    rstn = 1'b0;
    #1;
    checkResetOutputs("midjob");
    flushQueues();
    step(2);
    rstn = 1'b1;
    step(30);
    applyStimulus(2, 8'h80, 1'b1);
    waitDrain("job_after_reset", 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_rd_ctrl.md
MEM_RD_CTRL -- requirements
Module: mem_rd_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 16, element width and num_row width SHALL be this value.
REQ-002 Parameter ADDR_WIDTH, default 8, SHALL set the input-SRAM address width.
REQ-003 Parameter ARRAY_DIM, default 8, SHALL set the number of elements per row.
REQ-004 Parameter RD_LATENCY, default 1, SHALL set the SRAM read latency in cycles, legal range 1..4.
REQ-005 Parameter PIPE_LAT, default 2*ARRAY_DIM-1, SHALL set the array-entry-to-psum-out latency in cycles, minimum 1.
REQ-006 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-007 Port rstn, input, 1, SHALL be the reset, which is asynchronous and active-low.
REQ-008 Port start, input, 1, SHALL be a one-cycle request pulse, driven by the controller's mem_rd_ctrl_en.
REQ-009 Port num_row, input, DATA_WIDTH, SHALL give the rows per job and is sampled with start.
REQ-010 Port base_addr, input, ADDR_WIDTH, SHALL give the first row address and is sampled with start.
REQ-011 Port mem_rd_en, output, 1, SHALL be the SRAM read strobe.
REQ-012 Port mem_rd_addr, output, ADDR_WIDTH, SHALL be the SRAM read address.
REQ-013 Port mem_rd_data, input, ARRAY_DIM*DATA_WIDTH, SHALL carry the SRAM row data, valid RD_LATENCY cycles after mem_rd_en.
REQ-014 Port array_in_valid, output, 1, SHALL qualify array_in_data.
REQ-015 Port array_in_data, output, ARRAY_DIM*DATA_WIDTH, SHALL be the registered row to the systolic array.
REQ-016 Port sys_done, output, 1, SHALL mark one psum row leaving the array per high cycle.
REQ-017 Port busy, output, 1, SHALL be high while a job is in flight.
REQ-018 Port rd_done, output, 1, SHALL be a one-cycle end-of-job pulse.

Function
REQ-019 FSM states SHALL be IDLE, READ and DRAIN, and all outputs SHALL be registered.
REQ-020 IDLE: start with num_row>0 SHALL latch num_row and base_addr, go to READ, and set busy.
REQ-021 IDLE: start with num_row==0 SHALL leave the FSM in IDLE, issue no reads, and pulse rd_done in the next cycle with busy staying 0.
REQ-022 READ: mem_rd_en SHALL be high for exactly num_row consecutive cycles, beginning the cycle after start is sampled.
REQ-023 READ: mem_rd_addr SHALL equal base_addr+k in the k-th read cycle (k from 0), modulo 2^ADDR_WIDTH, so it wraps silently.
REQ-024 READ: after the last read the FSM SHALL go to DRAIN and deassert mem_rd_en.
REQ-025 Each read SHALL enter a valid delay line; array_in_valid SHALL rise RD_LATENCY cycles after the matching mem_rd_en cycle.
REQ-026 array_in_data SHALL equal mem_rd_data when array_in_valid is high, and hold its last value otherwise.
REQ-027 sys_done SHALL follow each array_in_valid by PIPE_LAT cycles, forming one contiguous high run of exactly num_row cycles.
REQ-028 DRAIN: when the delay line is empty and the last sys_done has passed, rd_done SHALL pulse, busy SHALL drop in the same cycle, and the FSM SHALL return to IDLE.
REQ-029 start while busy SHALL be ignored, with no relatch and no error.
REQ-030 start in the same cycle as rd_done SHALL be ignored; a new job needs start while busy==0.
REQ-031 The row counter SHALL be DATA_WIDTH bits wide, and num_row up to 2^DATA_WIDTH-1 SHALL be supported with no overflow.

Reset
REQ-032 On rstn low, regardless of clock, every output SHALL be cleared: mem_rd_en=0, mem_rd_addr=0, array_in_valid=0, array_in_data=0, sys_done=0, busy=0, rd_done=0.
REQ-033 On rstn low, the FSM SHALL go to IDLE and the delay line and counters SHALL be cleared.
REQ-034 Reset mid-job SHALL abort the job with no further reads or sys_done, and the first start after rstn rises SHALL be honoured.

Verification
REQ-035 Bench scenario, defaults: start at cycle 0 with num_row=4 and base_addr=0x10 -> mem_rd_en in cycles 1-4 at addresses 0x10-0x13, array_in_valid in cycles 2-5, sys_done in cycles 17-20, rd_done with busy falling at cycle 21.
REQ-036 Bench scenario: num_row=3 and base_addr=0xFE -> addresses 0xFE, 0xFF, 0x00.
REQ-037 Bench scenario: num_row=0 -> no mem_rd_en, rd_done at cycle 1, busy stays 0.
REQ-038 Bench scenario: a second start at cycle 3 of the first job -> ignored, and the sys_done count stays 4.
REQ-039 Bench scenario: rstn low at cycle 3 of a num_row=8 job -> all outputs 0 asynchronously, no sys_done afterwards, and a fresh job after release completes normally.
REQ-040 Bench scenario: back-to-back jobs with start one cycle after rd_done -> the second job's timing is identical to the first's.
